// File: rtl/tb_stim_driver.sv
// ============================================================================
//  Module   : tb_stim_driver
//  Purpose  : Stimulus transaction driver. Buffers stimulus words from a
//             valid/ready slave port in a small FIFO. Replays each word on a
//             valid/ready master port after a per-word idle gap, and counts
//             completed master-side transfers.
//  Ports    : tb_clk, tb_rst            - bench clock, async active-high reset
//             s_valid/s_ready/s_data/s_gap - stimulus slave port
//             m_valid/m_ready/m_data    - DUT-facing master port
//             fifo_count                - words buffered (excludes held word)
//             txn_count                 - completed master handshakes (wraps)
//             busy                      - FSM active or FIFO non-empty
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_stim_driver #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int GAP_W  = 4
) (
    input  logic                       tb_clk,
    input  logic                       tb_rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [DATA_W-1:0]          s_data,
    input  logic [GAP_W-1:0]           s_gap,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_W-1:0]          m_data,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [15:0]                txn_count,
    output logic                       busy
);

    localparam int                  c_ADDR_W = $clog2(DEPTH);
    localparam logic [c_ADDR_W:0]   c_FULL   = (c_ADDR_W + 1)'(DEPTH);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_GAP   = 2'd1;
    localparam logic [1:0] c_ST_DRIVE = 2'd2;

    // Each entry stores {data, gap}.
    logic [DATA_W+GAP_W-1:0] r_mem [DEPTH];
    logic [c_ADDR_W-1:0]     r_wr_ptr;
    logic [c_ADDR_W-1:0]     r_rd_ptr;
    logic [c_ADDR_W:0]       r_count;

    logic [1:0]              r_state;
    logic [GAP_W-1:0]        r_gap_cnt;
    logic                    r_m_valid;
    logic [DATA_W-1:0]       r_m_data;
    logic [15:0]             r_txn_count;

    logic                    w_push;
    logic                    w_pop;
    logic                    w_not_empty;
    logic [DATA_W+GAP_W-1:0] w_head;
    logic [DATA_W-1:0]       w_head_data;
    logic [GAP_W-1:0]        w_head_gap;

    logic [1:0]              w_state_nxt;
    logic [GAP_W-1:0]        w_gap_cnt_nxt;
    logic                    w_m_valid_nxt;
    logic [DATA_W-1:0]       w_m_data_nxt;

    // Full is judged on the current count only, so a same-cycle pop never
    // opens a slot for the push.
    assign s_ready     = (r_count < c_FULL) && !tb_rst;
    assign w_push      = s_valid && s_ready;
    assign w_not_empty = (r_count != '0);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_data = w_head[DATA_W+GAP_W-1:GAP_W];
    assign w_head_gap  = w_head[GAP_W-1:0];

    // Pop while idle, or in the same edge as a completed handshake.
    assign w_pop = w_not_empty &&
                   ((r_state == c_ST_IDLE) || ((r_state == c_ST_DRIVE) && m_ready));

    assign m_valid    = r_m_valid;
    assign m_data     = r_m_data;
    assign fifo_count = r_count;
    assign txn_count  = r_txn_count;
    assign busy       = (r_state != c_ST_IDLE) || w_not_empty;

    // Storage array needs no reset; pointers and count define validity.
    always_ff @(posedge tb_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {s_data, s_gap};
        end
    end

    always_ff @(posedge tb_clk or posedge tb_rst) begin
        if (tb_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_gap_cnt_nxt = r_gap_cnt;
        w_m_valid_nxt = r_m_valid;
        w_m_data_nxt  = r_m_data;

        case (r_state)
            c_ST_IDLE: begin
                w_m_valid_nxt = 1'b0;
            end
            c_ST_GAP: begin
                w_gap_cnt_nxt = r_gap_cnt - 1'b1;
                if (r_gap_cnt == GAP_W'(1)) begin
                    w_state_nxt   = c_ST_DRIVE;
                    w_m_valid_nxt = 1'b1;
                end
            end
            c_ST_DRIVE: begin
                // Word is held until accepted; with nothing queued, return idle.
                if (m_ready) begin
                    w_state_nxt   = c_ST_IDLE;
                    w_m_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt   = c_ST_IDLE;
                w_m_valid_nxt = 1'b0;
            end
        endcase

        // Loading a new word overrides the transitions above.
        if (w_pop) begin
            w_m_data_nxt = w_head_data;
            if (w_head_gap == '0) begin
                w_state_nxt   = c_ST_DRIVE;
                w_m_valid_nxt = 1'b1;
            end else begin
                w_state_nxt   = c_ST_GAP;
                w_gap_cnt_nxt = w_head_gap;
                w_m_valid_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge tb_clk or posedge tb_rst) begin
        if (tb_rst) begin
            r_state     <= c_ST_IDLE;
            r_gap_cnt   <= '0;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_txn_count <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_m_valid <= w_m_valid_nxt;
            r_m_data  <= w_m_data_nxt;
            if (r_m_valid && m_ready) begin
                r_txn_count <= r_txn_count + 16'd1;
            end
        end
    end

endmodule

`default_nettype wire
